// File: rtl/bsg_demodulator.sv
// PAM-4 receive slicer: hunts for idle, slices Gray-coded symbols, decodes bytes
// into a 2-entry FIFO. Define BSG_DEMOD_PARITY_EN to add an even-parity 5th symbol.
module bsg_demodulator #(
  parameter int          SPS        = 8,
  parameter logic [7:0]  IDLE_LEVEL = 8'h80,
  parameter logic [7:0]  TH_LO      = 8'h2B,
  parameter logic [7:0]  TH_MID     = 8'h80,
  parameter logic [7:0]  TH_HI      = 8'hD5
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST,
  input  logic [7:0] IN,
  input  logic       INTMSK,
  input  logic       CLR_OVR,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       OVR,
  output logic       PERR,
  output logic       BUSY,
  output logic       RX_INT
);

  localparam int SW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [SW-1:0] SMP_MID  = SW'(SPS / 2);
  localparam logic [SW-1:0] SMP_LAST = SW'(SPS - 1);

  typedef enum logic [1:0] {
    HUNT_IDLE  = 2'd0,
    WAIT_START = 2'd1,
    DATA       = 2'd2
`ifdef BSG_DEMOD_PARITY_EN
    ,PARITY    = 2'd3
`endif
  } state_e;

  function automatic logic [1:0] slice_level(input logic [7:0] s);
    logic [1:0] r;
    if (s < TH_LO)       r = 2'b00;
    else if (s < TH_MID) r = 2'b01;
    else if (s < TH_HI)  r = 2'b10;
    else                 r = 2'b11;
    return r;
  endfunction

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_e          state_q, state_d;
  logic [SW-1:0]   smp_q, smp_d;
  logic [2:0]      sym_q, sym_d;
  logic [7:0]      shift_q, shift_d;
  logic            done_q, done_d;
  logic            par_q, par_d;
  logic [1:0]      slice_s;
  logic [7:0]      dec_s;
  logic            par_ok_s;

  logic            push_q;
  logic [7:0]      pdata_q;
  logic [7:0]      mem_q [2];
  logic            head_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            pop_s, wr_s, ovr_set_s, perr_set_s;
  logic            ovr_q, ovr_d, perr_q, perr_d;

  assign slice_s = slice_level(IN);
  assign dec_s   = gray2bin(shift_q);
`ifdef BSG_DEMOD_PARITY_EN
  assign par_ok_s = (par_q == even_parity(dec_s));
`else
  assign par_ok_s = 1'b1;
`endif

  // Symbol-timing FSM next state: counters run free inside a byte, slice at mid-symbol
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    sym_d   = sym_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    par_d   = par_q;
    case (state_q)
      HUNT_IDLE: begin
        if (IN == IDLE_LEVEL) state_d = WAIT_START;
        else                  state_d = HUNT_IDLE;
      end
      WAIT_START: begin
        if (IN != IDLE_LEVEL) begin
          state_d = DATA;
          sym_d   = 3'd0;
          smp_d   = SW'(1);
        end else begin
          state_d = WAIT_START;
        end
      end
      DATA: begin
        if (smp_q == SMP_LAST) begin
          smp_d = '0;
          sym_d = sym_q + 3'd1;
        end else begin
          smp_d = smp_q + SW'(1);
        end
        if (smp_q == SMP_MID) begin
          shift_d = {shift_q[5:0], slice_s};
          if (sym_q == 3'd3) begin
`ifdef BSG_DEMOD_PARITY_EN
            state_d = PARITY;
`else
            state_d = HUNT_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef BSG_DEMOD_PARITY_EN
      PARITY: begin
        if (smp_q == SMP_LAST) begin
          smp_d = '0;
          sym_d = sym_q + 3'd1;
        end else begin
          smp_d = smp_q + SW'(1);
        end
        if ((smp_q == SMP_MID) && (sym_q == 3'd4)) begin
          par_d   = slice_s[0];
          done_d  = 1'b1;
          state_d = HUNT_IDLE;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      default: state_d = HUNT_IDLE;
    endcase
  end

  // Symbol-timing FSM registers
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= HUNT_IDLE;
      smp_q   <= '0;
      sym_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      sym_q   <= sym_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      par_q   <= par_d;
    end
  end

  // Decode stage: registers the binary byte one cycle after assembly
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      push_q  <= 1'b0;
      pdata_q <= 8'h00;
    end else begin
      push_q  <= done_q & par_ok_s;
      pdata_q <= dec_s;
    end
  end

  assign perr_set_s = done_q & ~par_ok_s;
  assign pop_s      = (cnt_q != 2'd0) & RX_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_s       = push_q & ((cnt_q != 2'd2) | pop_s);
  assign ovr_set_s  = push_q & (cnt_q == 2'd2) & ~pop_s;

  // FIFO occupancy and sticky flag next state; set beats clear
  always_comb begin
    cnt_d = cnt_q + {1'b0, wr_s} - {1'b0, pop_s};
    if (ovr_set_s)    ovr_d = 1'b1;
    else if (CLR_OVR) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
    if (perr_set_s)   perr_d = 1'b1;
    else if (CLR_OVR) perr_d = 1'b0;
    else              perr_d = perr_q;
  end

  // FIFO storage, pointers and sticky flags
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      mem_q[0] <= 8'h00;
      mem_q[1] <= 8'h00;
      head_q   <= 1'b0;
      cnt_q    <= 2'd0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (wr_s) mem_q[head_q ^ cnt_q[0]] <= pdata_q;
      if (pop_s) head_q <= ~head_q;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      perr_q <= perr_d;
    end
  end

  assign RX_DATA  = mem_q[head_q];
  assign RX_VALID = (cnt_q != 2'd0);
  assign OVR      = ovr_q;
`ifdef BSG_DEMOD_PARITY_EN
  assign PERR     = perr_q;
  assign BUSY     = (state_q == DATA) || (state_q == PARITY);
`else
  assign PERR     = 1'b0;
  assign BUSY     = (state_q == DATA);
`endif
  assign RX_INT   = INTMSK & (RX_VALID | OVR | PERR);

endmodule

// File: tb/tb_bsg_demodulator.sv
// Scoreboard bench for bsg_demodulator: encodes bytes to PAM-4 Gray symbols,
// checks popped bytes, latency, overrun, reset and (optionally) parity.
module tb_bsg_demodulator;

  localparam int SPS = 8;
`ifdef BSG_DEMOD_PARITY_EN
  localparam int NSYM = 5;
`else
  localparam int NSYM = 4;
`endif
  localparam int NSMP = NSYM * SPS;
  localparam logic [7:0] IDLE = 8'h80;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] in_s    = 8'h80;
  logic       intmsk  = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       ovr, perr, busy, rx_int;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb_q [$];

  bsg_demodulator #(.SPS(SPS)) dut (
    .SYS_CLK(sys_clk), .SYS_RST(sys_rst), .IN(in_s), .INTMSK(intmsk),
    .CLR_OVR(clr_ovr), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RX_READY(rx_ready), .OVR(ovr), .PERR(perr), .BUSY(busy), .RX_INT(rx_int)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] level_of(input logic [1:0] p);
    case (p)
      2'b00:   return 8'h00;
      2'b01:   return 8'h55;
      2'b10:   return 8'hAA;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] good_par(input logic [7:0] b);
    return level_of({1'b0, ^b});
  endfunction

  // One idle separator, then NSYM symbols of SPS samples; ready_k pulses RX_READY.
  task automatic send_byte(input logic [7:0] b, input bit accept, input bit chk_t,
                           input int ready_k, input logic [7:0] par_lvl);
    logic [7:0] g;
    int sym;
    g = b ^ (b >> 1);
    in_s = IDLE;
    tick();
    if (accept) sb_q.push_back(b);
    for (int k = 0; k < NSMP; k++) begin
      sym = k / SPS;
      if (sym < 4) in_s = level_of(g[7-2*sym -: 2]);
      else         in_s = par_lvl;
      if (ready_k >= 0) rx_ready = (k == ready_k);
      tick();
      if (chk_t) begin
        check($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, k <= NSMP - 5});
        check($sformatf("valid_k%0d", k), {31'd0, rx_valid}, {31'd0, k >= NSMP - 2});
      end
    end
    if (ready_k >= 0) rx_ready = 1'b0;
    in_s = IDLE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    rx_ready = 1'b0;
    check("drain_empty", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_data"},  {24'd0, rx_data},  32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_ovr"},   {31'd0, ovr},      32'd0);
    check({tag, "_perr"},  {31'd0, perr},     32'd0);
    check({tag, "_int"},   {31'd0, rx_int},   32'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    in_s = IDLE;
    tick();
    tick();
    check_all_zero("reset");
    sys_rst = 1'b0;
  endtask

  // Scoreboard consumer: every accepted pop must match the oldest expected byte
  always @(negedge sys_clk) begin
    if (!sys_rst && rx_valid && rx_ready) begin
      if (sb_q.size() == 0) check("pop_with_empty_scoreboard", 32'(sb_q.size()), 32'd1);
      else check("pop_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    intmsk = 1'b1;
    do_reset();

    // Basic byte with latency and BUSY window
    for (int i = 0; i < 9; i++) tick();
    send_byte(8'h5A, 1'b1, 1'b1, -1, good_par(8'h5A));
    check("t1_data", {24'd0, rx_data}, 32'h5A);
    check("t1_int", {31'd0, rx_int}, 32'd1);
    drain();

    // Overrun with three bytes and no consumer
    send_byte(8'h00, 1'b1, 1'b0, -1, good_par(8'h00));
    send_byte(8'hFF, 1'b1, 1'b0, -1, good_par(8'hFF));
    send_byte(8'h3C, 1'b0, 1'b0, -1, good_par(8'h3C));
    tick();
    check("t2_ovr", {31'd0, ovr}, 32'd1);
    check("t2_head", {24'd0, rx_data}, 32'h00);
    check("t2_int_on", {31'd0, rx_int}, 32'd1);
    intmsk = 1'b0;
    #1;
    check("t2_int_off", {31'd0, rx_int}, 32'd0);
    intmsk = 1'b1;
    drain();
    check("t2_ovr_kept", {31'd0, ovr}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("t2_ovr_clr", {31'd0, ovr}, 32'd0);
    check("t2_int_clr", {31'd0, rx_int}, 32'd0);

    // Full FIFO with a pop in the exact push cycle
    send_byte(8'h12, 1'b1, 1'b0, -1, good_par(8'h12));
    send_byte(8'hC3, 1'b1, 1'b0, -1, good_par(8'hC3));
    send_byte(8'h7E, 1'b1, 1'b0, NSMP - 2, good_par(8'h7E));
    tick();
    check("t3_no_ovr", {31'd0, ovr}, 32'd0);
    check("t3_head", {24'd0, rx_data}, 32'hC3);
    drain();

    // Stuck non-idle line never starts a byte
    do_reset();
    in_s = 8'hAA;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("t4_valid", {31'd0, rx_valid}, 32'd0);
      check("t4_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-byte discards FIFO and partial byte
    do_reset();
    send_byte(8'h11, 1'b0, 1'b0, -1, good_par(8'h11));
    in_s = IDLE;
    tick();
    for (int k = 0; k < 2 * SPS + 3; k++) begin
      in_s = 8'hFF;
      tick();
    end
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    sys_rst = 1'b1;
    tick();
    check_all_zero("t5");
    sys_rst = 1'b0;
    in_s = 8'hAA;
    for (int i = 0; i < SPS; i++) tick();
    send_byte(8'hA5, 1'b1, 1'b0, -1, good_par(8'hA5));
    tick();
    check("t5_data", {24'd0, rx_data}, 32'hA5);
    drain();

`ifdef BSG_DEMOD_PARITY_EN
    // Parity accept and reject
    send_byte(8'h5A, 1'b1, 1'b0, -1, 8'h00);
    tick();
    check("t6_perr_ok", {31'd0, perr}, 32'd0);
    drain();
    send_byte(8'h5A, 1'b0, 1'b0, -1, 8'hFF);
    tick();
    tick();
    check("t6_perr_set", {31'd0, perr}, 32'd1);
    check("t6_dropped", {31'd0, rx_valid}, 32'd0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("t6_perr_clr", {31'd0, perr}, 32'd0);
`else
    check("perr_tied", {31'd0, perr}, 32'd0);
`endif

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
